sm83_flag_unit: RTL
===================

# sm83_flag_unit

Flag register and carry-chain sequencer for the SM83 core. Holds F (Z, N, H, C) and latches per-flag results from the ALU, shifter and DAA corrector, and supplies zero, carry, daa_carry, daa_neg and pri_carry to the ALU control stage. A small state machine runs the two-byte ALU passes of the 16-bit ops (ADD HL,rr; ADD SP,e; INC/DEC rr), with two jobs:
- chain the low-byte carry into the high byte;
- commit the architecturally correct flags at the end of the pass.

## Interface
No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result flags below are valid this cycle
- alu_z, alu_h, alu_c  in  1 each  ALU zero, half-carry and carry of the current byte
- n_val  in  1  value written to N when we_n
- shift_out  in  1  carry out of the shifter
- daa_carry_out  in  1  carry out of the DAA corrector
- we_z, we_n, we_h, we_c  in  1 each  per-flag write enables (8-bit ops)
- c_sel  in  3  C source: 0 alu_c, 1 shift_out, 2 daa_carry_out, 3 set (SCF), 4 invert (CCF); 5-7 hold
- cin_use_c  in  1  ALU carry-in = F.C (ADC/SBC/RL/RR) while idle
- f_load  in  1  load F from dbus_in[7:4] (POP AF)
- dbus_in  in  8  data bus
- op16_start  in  1  start a 16-bit pass
- op16_kind  in  2  0 ADD HL,rr; 1 ADD SP,e; 2 INC rr; 3 DEC rr
- e_sign  in  1  bit 7 of e, sampled with op16_start
- f_out  out  8  {Z,N,H,C,4'b0000}
- zero, carry, daa_carry, daa_neg  out  1 each  F.Z, F.C, F.H, F.N
- pri_carry  out  1  primary carry buffer (last latched byte carry)
- alu_cin  out  1  carry-in to ALU
- hi_ext  out  8  high-byte operand extension for ADD SP,e
- busy  out  1  16-bit pass in progress
- op16_done  out  1  one-cycle pulse after 16-bit commit

## Operation
- Reset values: F=0x0, f_out=0x00, pri_carry=0, state IDLE, busy=0, op16_done=0, hi_ext=0x00, alu_cin=0.
- States: IDLE, LOW, HIGH.
- Priority each edge, high to low: f_load, then 16-bit commit, then per-flag writes.
- f_load sets F <= dbus_in[7:4]. dbus_in[3:0] is ignored, so f_out[3:0] is always 0.
- IDLE, 8-bit writes:
  - we_z: Z <= alu_z. we_n: N <= n_val. we_h: H <= alu_h.
  - we_c: C <= the value selected by c_sel; c_sel 5-7 leaves C unchanged.
  - Writes apply regardless of alu_valid; the sequencer guarantees alignment.
- Primary carry buffer: pri_carry <= alu_c on every cycle where alu_valid=1, in any state.
- alu_cin:
  - IDLE: F.C & cin_use_c.
  - LOW: 0.
  - HIGH: pri_carry.
- IDLE -> LOW on op16_start. On that edge, latch kind and e_sign; busy=1 from the next cycle.
- LOW -> HIGH on alu_valid. On that edge, also latch lo_h=alu_h and lo_c=alu_c.
- HIGH -> IDLE on alu_valid. The commit on that edge depends on kind:
  - ADD HL: N=0, H=alu_h, C=alu_c; Z unchanged.
  - ADD SP,e: Z=0, N=0, H=lo_h, C=lo_c.
  - INC/DEC: F unchanged.
- op16_done=1 for exactly the cycle after the HIGH->IDLE edge.
- hi_ext = 0xFF in HIGH when kind=ADD SP and e_sign=1; otherwise 0x00.
- Boundary conditions:
  - op16_start while busy: ignored.
  - we_* while busy: ignored.
  - f_load while busy: applied. If it coincides with the commit, f_load wins, but the FSM still returns to IDLE and pulses op16_done.
  - Reset mid-pass: immediate return to IDLE, all outputs to reset values.

## Timing
- Flag outputs are registered: a write on edge N is visible after edge N.
- alu_cin, hi_ext and busy are combinational from registered state; they have no dependency on the alu_* inputs in the same cycle.
- Minimum 16-bit pass: start edge, LOW edge, HIGH edge.
  - busy is high for 2 cycles.
  - op16_done is high in the 3rd cycle after the start.
- LOW and HIGH hold indefinitely while alu_valid=0.

## Test plan
- Reset then 8-bit write: assert reset_n=0 -> f_out=0x00. Release; we_z/we_h/we_c with alu_z=1, alu_h=0, alu_c=1, c_sel=0 -> f_out=0x90.
- C sources, starting from C=1:
  - c_sel=4 -> C=0.
  - then c_sel=3 -> C=1.
  - then c_sel=2 with daa_carry_out=0 -> C=0.
  - c_sel=6 -> C unchanged.
- ADD HL chain, with Z=1 preset:
  - LOW alu_c=1 -> alu_cin=1 in HIGH.
  - HIGH alu_h=1, alu_c=0 -> f_out=0xA0.
  - op16_done pulses once.
- ADD SP,e with e_sign=1:
  - hi_ext=0xFF in HIGH.
  - LOW alu_h=1, alu_c=1; HIGH alu_h=0, alu_c=0 -> f_out=0x30 (Z=0, N=0).
- INC rr with F=0xF0 -> F stays 0xF0. op16_start during busy -> no restart; busy drops after 2 cycles.
- Mid-pass events:
  - f_load with dbus_in=0x5A coinciding with the ADD HL commit -> f_out=0x50, FSM IDLE, op16_done=1.
  - reset_n low in HIGH -> IDLE, busy=0, pri_carry=0.

Source files
------------

// File: rtl/sm83_flag_unit.sv
// SM83 flag register (Z N H C) with the carry-chain sequencer for 16-bit ALU passes.
// Ports: clk/reset_n; alu_*/shift/daa flag sources; we_*/c_sel writes; f_load/dbus_in; op16_* control; f_out and flag taps, pri_carry, alu_cin, hi_ext, busy, op16_done.
module sm83_flag_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alu_valid,
    input  logic       alu_z,
    input  logic       alu_h,
    input  logic       alu_c,
    input  logic       n_val,
    input  logic       shift_out,
    input  logic       daa_carry_out,
    input  logic       we_z,
    input  logic       we_n,
    input  logic       we_h,
    input  logic       we_c,
    input  logic [2:0] c_sel,
    input  logic       cin_use_c,
    input  logic       f_load,
    input  logic [7:0] dbus_in,
    input  logic       op16_start,
    input  logic [1:0] op16_kind,
    input  logic       e_sign,
    output logic [7:0] f_out,
    output logic       zero,
    output logic       carry,
    output logic       daa_carry,
    output logic       daa_neg,
    output logic       pri_carry,
    output logic       alu_cin,
    output logic [7:0] hi_ext,
    output logic       busy,
    output logic       op16_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    localparam logic [1:0] K_ADD_HL = 2'd0;
    localparam logic [1:0] K_ADD_SP = 2'd1;

    state_t     state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic       esign_q, esign_d;
    logic       lo_h_q, lo_h_d;
    logic       lo_c_q, lo_c_d;
    logic       pri_q, pri_d;
    logic       done_q, done_d;
    logic       z_q, z_d;
    logic       n_q, n_d;
    logic       h_q, h_d;
    logic       c_q, c_d;
    logic       commit;
    logic       c_new;

    // The low nibble of the bus has no flag meaning.
    logic unused_dbus_lo;
    assign unused_dbus_lo = ^dbus_in[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q  <= 2'd0;
            esign_q <= 1'b0;
            lo_h_q  <= 1'b0;
            lo_c_q  <= 1'b0;
            pri_q   <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            h_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            kind_q  <= kind_d;
            esign_q <= esign_d;
            lo_h_q  <= lo_h_d;
            lo_c_q  <= lo_c_d;
            pri_q   <= pri_d;
            done_q  <= done_d;
            z_q     <= z_d;
            n_q     <= n_d;
            h_q     <= h_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        esign_d = esign_q;
        lo_h_d  = lo_h_q;
        lo_c_d  = lo_c_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op16_start) begin
                    state_d = S_LOW;
                    kind_d  = op16_kind;
                    esign_d = e_sign;
                end
            end
            S_LOW: begin
                if (alu_valid) begin
                    state_d = S_HIGH;
                    lo_h_d  = alu_h;
                    lo_c_d  = alu_c;
                end
            end
            S_HIGH: begin
                if (alu_valid) begin
                    state_d = S_IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (c_sel)
            3'd0:    c_new = alu_c;
            3'd1:    c_new = shift_out;
            3'd2:    c_new = daa_carry_out;
            3'd3:    c_new = 1'b1;
            3'd4:    c_new = ~c_q;
            default: c_new = c_q;
        endcase
    end

    // f_load beats the 16-bit commit, which beats 8-bit writes (idle only).
    always_comb begin
        z_d = z_q;
        n_d = n_q;
        h_d = h_q;
        c_d = c_q;
        if (f_load) begin
            {z_d, n_d, h_d, c_d} = dbus_in[7:4];
        end else if (commit) begin
            if (kind_q == K_ADD_HL) begin
                n_d = 1'b0;
                h_d = alu_h;
                c_d = alu_c;
            end else if (kind_q == K_ADD_SP) begin
                z_d = 1'b0;
                n_d = 1'b0;
                h_d = lo_h_q;
                c_d = lo_c_q;
            end
        end else if (state_q == S_IDLE) begin
            if (we_z) z_d = alu_z;
            if (we_n) n_d = n_val;
            if (we_h) h_d = alu_h;
            if (we_c) c_d = c_new;
        end
    end

    always_comb begin
        pri_d  = alu_valid ? alu_c : pri_q;
        done_d = commit;
    end

    always_comb begin
        alu_cin = 1'b0;
        hi_ext  = 8'h00;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: alu_cin = c_q & cin_use_c;
            S_HIGH: begin
                alu_cin = pri_q;
                if (kind_q == K_ADD_SP && esign_q) hi_ext = 8'hFF;
            end
            default: alu_cin = 1'b0;
        endcase
    end

    assign f_out     = {z_q, n_q, h_q, c_q, 4'b0000};
    assign zero      = z_q;
    assign carry     = c_q;
    assign daa_carry = h_q;
    assign daa_neg   = n_q;
    assign pri_carry = pri_q;
    assign op16_done = done_q;

endmodule
